// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
// CSR addresses, the csr_op encoding, mstatus/mip bit positions and
// counter half-select values used by csr_unit and csr_counter.
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MTIMECMP      = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH     = 12'h7C1;
    localparam logic [11:0] CSR_MTIME         = 12'h7C2;
    localparam logic [11:0] CSR_MTIMEH        = 12'h7C3;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    // csr_op encoding; READ performs no write
    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mip bit positions
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // mcountinhibit bit positions
    localparam int MCI_CY = 0;
    localparam int MCI_IR = 2;

    // Counter half select: mtime/mtimecmp halves differ in addr[0]
    localparam logic CNT_HALF_LO = 1'b0;
    localparam logic CNT_HALF_HI = 1'b1;

    // misa: MXL=1 (32-bit), I extension
    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

endpackage

// File: rtl/csr_counter.sv
// csr_counter: W-bit free-running counter with split lo/hi CSR load.
// A load of either half in a cycle holds the other half and suppresses
// the increment for that cycle; the count wraps to 0 at 2^W.
module csr_counter
    import csr_pkg::*;
#(
    parameter int W  = 64,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_en,
    input  logic          i_load_lo,
    input  logic          i_load_hi,
    input  logic [DW-1:0] i_data,
    output logic [W-1:0]  o_count
);

    localparam int          HW      = W - DW;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_count;

    // Count register: CSR load has priority over the increment
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_count <= {W{1'b0}};
        end else if (i_load_lo) begin
            r_count <= {r_count[W-1:DW], i_data};
        end else if (i_load_hi) begin
            r_count <= {i_data[HW-1:0], r_count[DW-1:0]};
        end else if (i_en) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with CSRRW/RS/RC access, trap/mret
// sequencing, cycle/instret counters and a prescaled mtime timer.
// Optional macro CSR_COUNTINHIBIT_EN adds mcountinhibit at 0x320.
// Note: resetn is asynchronous and active-high despite its name.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 64,
    parameter int              TIMER_DIV   = 1,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [XLEN-1:0] HART_ID     = 32'd0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            csr_req,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_ack,
    output logic            csr_illegal,
    input  logic            instret_inc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            irq_ext,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            timer_irq,
    output logic            irq_pending
);

    localparam int              HW         = CNT_W - XLEN;
    localparam int              PW         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TIMER_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [XLEN-1:0] MISA_VAL   = XLEN'(MISA_RV32I);
    localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};

    // Architectural state
    logic            r_mstatus_mie, r_mstatus_mpie;
    logic [1:0]      r_mstatus_mpp;
    logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic            r_msip, r_meip, r_timer_irq, r_irq_pending;
    logic [CNT_W-1:0] r_mtimecmp;
    logic [PW-1:0]   r_presc;
    logic [XLEN-1:0] r_rdata;
    logic            r_ack, r_illegal;

    // Combinational decode
    logic [CNT_W-1:0] w_mcycle, w_minstret, w_mtime;
    logic [XLEN-1:0]  w_mstatus, w_mip, w_mcountinhibit, w_old, w_new;
    logic             w_mapped, w_is_write, w_illegal, w_we, w_tick;
    logic             w_cy_en, w_ir_en;

`ifdef CSR_COUNTINHIBIT_EN
    logic r_cy_inh, r_ir_inh;

    // mcountinhibit: CY and IR freeze bits
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_cy_inh <= 1'b0;
            r_ir_inh <= 1'b0;
        end else if (w_we && (csr_addr == CSR_MCOUNTINHIBIT)) begin
            r_cy_inh <= w_new[MCI_CY];
            r_ir_inh <= w_new[MCI_IR];
        end else begin
            r_cy_inh <= r_cy_inh;
            r_ir_inh <= r_ir_inh;
        end
    end

    assign w_cy_en = ~r_cy_inh;
    assign w_ir_en = instret_inc & ~r_ir_inh;

    // Readback value of mcountinhibit
    always_comb begin
        w_mcountinhibit         = ZERO;
        w_mcountinhibit[MCI_CY] = r_cy_inh;
        w_mcountinhibit[MCI_IR] = r_ir_inh;
    end
`else
    assign w_cy_en         = 1'b1;
    assign w_ir_en         = instret_inc;
    assign w_mcountinhibit = ZERO;
`endif

    // Compose mstatus and mip read values from their implemented bits
    always_comb begin
        w_mstatus                               = ZERO;
        w_mstatus[MSTATUS_MIE]                  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE]                 = r_mstatus_mpie;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = r_mstatus_mpp;
        w_mip                                   = ZERO;
        w_mip[MIP_MSIP]                         = r_msip;
        w_mip[MIP_MTIP]                         = r_timer_irq;
        w_mip[MIP_MEIP]                         = r_meip;
    end

    // Address decode and old-value read mux; unmapped reads 0
    always_comb begin
        w_old    = ZERO;
        w_mapped = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MISA:      w_old = MISA_VAL;
            CSR_MIE:       w_old = r_mie;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MTVAL:     w_old = r_mtval;
            CSR_MIP:       w_old = w_mip;
            CSR_MCYCLE:    w_old = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH:   w_old = XLEN'(w_mcycle >> XLEN);
            CSR_MINSTRET:  w_old = w_minstret[XLEN-1:0];
            CSR_MINSTRETH: w_old = XLEN'(w_minstret >> XLEN);
            CSR_MTIMECMP:  w_old = r_mtimecmp[XLEN-1:0];
            CSR_MTIMECMPH: w_old = XLEN'(r_mtimecmp >> XLEN);
            CSR_MTIME:     w_old = w_mtime[XLEN-1:0];
            CSR_MTIMEH:    w_old = XLEN'(w_mtime >> XLEN);
            CSR_MVENDORID: w_old = ZERO;
            CSR_MARCHID:   w_old = ZERO;
            CSR_MIMPID:    w_old = ZERO;
            CSR_MHARTID:   w_old = HART_ID;
`ifdef CSR_COUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT: w_old = w_mcountinhibit;
`endif
            default: begin
                w_old    = ZERO;
                w_mapped = 1'b0;
            end
        endcase
    end

    // Operation: new value and whether a write happens at all
    always_comb begin
        w_new      = w_old;
        w_is_write = 1'b0;
        case (csr_op)
            CSR_OP_RW: begin
                w_new      = csr_wdata;
                w_is_write = 1'b1;
            end
            CSR_OP_RS: begin
                w_new      = w_old | csr_wdata;
                w_is_write = |csr_wdata;
            end
            CSR_OP_RC: begin
                w_new      = w_old & ~csr_wdata;
                w_is_write = |csr_wdata;
            end
            default: begin
                w_new      = w_old;
                w_is_write = 1'b0;
            end
        endcase
    end

    assign w_illegal = ~w_mapped | (w_is_write & (csr_addr[11:10] == 2'b11));
    assign w_we      = csr_req & w_is_write & ~w_illegal;

    // Read/ack handshake: one-cycle ack with pre-write data
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_ack     <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= ZERO;
        end else begin
            r_ack     <= csr_req;
            r_illegal <= csr_req & w_illegal;
            r_rdata   <= (csr_req && !w_illegal) ? w_old : ZERO;
        end
    end

    // mstatus: trap beats mret beats a CSR write
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mstatus_mpp  <= 2'b00;
        end else if (trap_valid) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpp  <= 2'b11;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we && (csr_addr == CSR_MSTATUS)) begin
            r_mstatus_mie  <= w_new[MSTATUS_MIE];
            r_mstatus_mpie <= w_new[MSTATUS_MPIE];
            r_mstatus_mpp  <= w_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end else begin
            r_mstatus_mie  <= r_mstatus_mie;
        end
    end

    // Plain read/write registers untouched by traps
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_mie      <= ZERO;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= ZERO;
            r_msip     <= 1'b0;
        end else begin
            if (w_we && (csr_addr == CSR_MIE))      r_mie      <= w_new;
            else                                    r_mie      <= r_mie;
            if (w_we && (csr_addr == CSR_MTVEC))    r_mtvec    <= w_new;
            else                                    r_mtvec    <= r_mtvec;
            if (w_we && (csr_addr == CSR_MSCRATCH)) r_mscratch <= w_new;
            else                                    r_mscratch <= r_mscratch;
            if (w_we && (csr_addr == CSR_MIP))      r_msip     <= w_new[MIP_MSIP];
            else                                    r_msip     <= r_msip;
        end
    end

    // Trap-captured registers: trap entry wins over a CSR write
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_mepc   <= ZERO;
            r_mcause <= ZERO;
            r_mtval  <= ZERO;
        end else if (trap_valid) begin
            r_mepc   <= trap_pc & ~XLEN'(3);
            r_mcause <= trap_cause;
            r_mtval  <= trap_tval;
        end else begin
            if (w_we && (csr_addr == CSR_MEPC))   r_mepc   <= w_new;
            else                                  r_mepc   <= r_mepc;
            if (w_we && (csr_addr == CSR_MCAUSE)) r_mcause <= w_new;
            else                                  r_mcause <= r_mcause;
            if (w_we && (csr_addr == CSR_MTVAL))  r_mtval  <= w_new;
            else                                  r_mtval  <= r_mtval;
        end
    end

    // mtimecmp: resets to all-ones so the timer cannot fire after reset
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_mtimecmp <= {CNT_W{1'b1}};
        end else if (w_we && (csr_addr[11:1] == CSR_MTIMECMP[11:1])) begin
            if (csr_addr[0] == CNT_HALF_LO) r_mtimecmp <= {r_mtimecmp[CNT_W-1:XLEN], w_new};
            else                            r_mtimecmp <= {w_new[HW-1:0], r_mtimecmp[XLEN-1:0]};
        end else begin
            r_mtimecmp <= r_mtimecmp;
        end
    end

    // mtime prescaler: counts 0..TIMER_DIV-1, ticks on wrap
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)                   r_presc <= {PW{1'b0}};
        else if (r_presc == PRESC_LAST) r_presc <= {PW{1'b0}};
        else                          r_presc <= r_presc + PRESC_ONE;
    end

    assign w_tick = (r_presc == PRESC_LAST);

    // Interrupt state: registered compare, external sync, pending flag
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_timer_irq   <= 1'b0;
            r_meip        <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_timer_irq   <= (w_mtime >= r_mtimecmp);
            r_meip        <= irq_ext;
            r_irq_pending <= r_mstatus_mie & (|(r_mie & w_mip));
        end
    end

    csr_counter #(.W(CNT_W), .DW(XLEN)) u_mcycle (
        .clk       (clk),
        .resetn    (resetn),
        .i_en      (w_cy_en),
        .i_load_lo (w_we && (csr_addr == CSR_MCYCLE)),
        .i_load_hi (w_we && (csr_addr == CSR_MCYCLEH)),
        .i_data    (w_new),
        .o_count   (w_mcycle)
    );

    csr_counter #(.W(CNT_W), .DW(XLEN)) u_minstret (
        .clk       (clk),
        .resetn    (resetn),
        .i_en      (w_ir_en),
        .i_load_lo (w_we && (csr_addr == CSR_MINSTRET)),
        .i_load_hi (w_we && (csr_addr == CSR_MINSTRETH)),
        .i_data    (w_new),
        .o_count   (w_minstret)
    );

    csr_counter #(.W(CNT_W), .DW(XLEN)) u_mtime (
        .clk       (clk),
        .resetn    (resetn),
        .i_en      (w_tick),
        .i_load_lo (w_we && (csr_addr == CSR_MTIME)),
        .i_load_hi (w_we && (csr_addr == CSR_MTIMEH)),
        .i_data    (w_new),
        .o_count   (w_mtime)
    );

    assign csr_rdata   = r_rdata;
    assign csr_ack     = r_ack;
    assign csr_illegal = r_illegal;
    assign mtvec       = r_mtvec;
    assign mepc        = r_mepc;
    assign timer_irq   = r_timer_irq;
    assign irq_pending = r_irq_pending;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed-vector self-checking bench for csr_unit.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_ack, csr_illegal;
    logic        instret_inc, trap_valid, mret, irq_ext;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic [31:0] mtvec, mepc;
    logic        timer_irq, irq_pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        ill, ack, found;

    always #5 clk = ~clk;

    csr_unit #(
        .XLEN(32), .CNT_W(64), .TIMER_DIV(4),
        .MTVEC_RESET(32'h8000_0000), .HART_ID(32'd5)
    ) dut (
        .clk(clk), .resetn(resetn),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_ack(csr_ack), .csr_illegal(csr_illegal),
        .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .irq_ext(irq_ext),
        .mtvec(mtvec), .mepc(mepc), .timer_irq(timer_irq), .irq_pending(irq_pending)
    );

    // Compare one observed value against its hand-computed expectation
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One CSR request sampled at the next edge; returns ack-cycle outputs
    task automatic csr_xfer(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                            output logic [31:0] r, output logic il, output logic ak);
        csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
        @(posedge clk); #1;
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
        r = csr_rdata; il = csr_illegal; ak = csr_ack;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; csr_req = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
        instret_inc = 1'b0; trap_valid = 1'b0; mret = 1'b0; irq_ext = 1'b0;
        trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
        tick(2);
        check_eq("rst_ack", csr_ack, 1'b0);
        check_eq("rst_rdata", csr_rdata, 32'h0);
        check_eq("rst_illegal", csr_illegal, 1'b0);
        check_eq("rst_timer_irq", timer_irq, 1'b0);
        check_eq("rst_irq_pending", irq_pending, 1'b0);
        check_eq("rst_mtvec", mtvec, 32'h8000_0000);
        check_eq("rst_mepc", mepc, 32'h0);
        resetn = 1'b0;
        tick(1);

        // mtvec read/write
        csr_xfer(2'b01, 12'h305, 32'h100, rd, ill, ack);
        check_eq("mtvec_rw_ack", ack, 1'b1);
        check_eq("mtvec_rw_old", rd, 32'h8000_0000);
        check_eq("mtvec_rw_ill", ill, 1'b0);
        tick(1);
        check_eq("ack_one_cycle", csr_ack, 1'b0);
        csr_xfer(2'b00, 12'h305, 32'h0, rd, ill, ack);
        check_eq("mtvec_read", rd, 32'h100);
        check_eq("mtvec_port", mtvec, 32'h100);

        // set/clear on mstatus, read-only and unmapped accesses
        csr_xfer(2'b10, 12'h300, 32'h8, rd, ill, ack);
        check_eq("mstatus_rs_old", rd, 32'h0);
        csr_xfer(2'b11, 12'h300, 32'h8, rd, ill, ack);
        check_eq("mstatus_rc_old", rd, 32'h8);
        csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check_eq("mstatus_cleared", rd, 32'h0);
        csr_xfer(2'b10, 12'hF14, 32'h0, rd, ill, ack);
        check_eq("hartid_rs0", rd, 32'd5);
        check_eq("hartid_rs0_ill", ill, 1'b0);
        csr_xfer(2'b01, 12'hF14, 32'h7, rd, ill, ack);
        check_eq("hartid_rw_ill", ill, 1'b1);
        check_eq("hartid_rw_rdata", rd, 32'h0);
        check_eq("hartid_rw_ack", ack, 1'b1);
        csr_xfer(2'b00, 12'hF14, 32'h0, rd, ill, ack);
        check_eq("hartid_unchanged", rd, 32'd5);
        csr_xfer(2'b00, 12'h123, 32'h0, rd, ill, ack);
        check_eq("unmapped_ill", ill, 1'b1);
        check_eq("unmapped_rdata", rd, 32'h0);
        csr_xfer(2'b01, 12'h301, 32'h0, rd, ill, ack);
        check_eq("misa_wr_ill", ill, 1'b0);
        csr_xfer(2'b00, 12'h301, 32'h0, rd, ill, ack);
        check_eq("misa_ro", rd, 32'h4000_0100);
        csr_xfer(2'b00, 12'h320, 32'h0, rd, ill, ack);
`ifdef CSR_COUNTINHIBIT_EN
        check_eq("mcountinhibit_ill", ill, 1'b0);
`else
        check_eq("mcountinhibit_ill", ill, 1'b1);
`endif

        // mcycle lo wrap carries into hi
        csr_xfer(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, ill, ack);
        csr_xfer(2'b01, 12'hB80, 32'h0, rd, ill, ack);
        check_eq("mcycleh_old", rd, 32'h0);
        csr_xfer(2'b00, 12'hB00, 32'h0, rd, ill, ack);
        check_eq("mcycle_lo_held", rd, 32'hFFFF_FFFF);
        csr_xfer(2'b00, 12'hB80, 32'h0, rd, ill, ack);
        check_eq("mcycle_hi_carry", rd, 32'h1);

        // minstret counts only retired instructions
        csr_xfer(2'b00, 12'hB02, 32'h0, rd, ill, ack);
        check_eq("minstret_idle", rd, 32'h0);
        instret_inc = 1'b1;
        tick(3);
        instret_inc = 1'b0;
        csr_xfer(2'b00, 12'hB02, 32'h0, rd, ill, ack);
        check_eq("minstret_3", rd, 32'h3);

        // trap entry and mret
        csr_xfer(2'b10, 12'h300, 32'h8, rd, ill, ack);
        trap_valid = 1'b1; trap_pc = 32'h1002; trap_cause = 32'h8000_0007; trap_tval = 32'h55;
        tick(1);
        trap_valid = 1'b0;
        check_eq("trap_mepc", mepc, 32'h1000);
        csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check_eq("trap_mstatus", rd, 32'h1880);
        csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, ack);
        check_eq("trap_mcause", rd, 32'h8000_0007);
        csr_xfer(2'b00, 12'h343, 32'h0, rd, ill, ack);
        check_eq("trap_mtval", rd, 32'h55);
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check_eq("mret_mstatus", rd, 32'h1888);

        // trap + mret + CSR write to mepc in one cycle: trap wins
        trap_valid = 1'b1; mret = 1'b1; trap_pc = 32'h2003;
        csr_xfer(2'b01, 12'h341, 32'hABC, rd, ill, ack);
        trap_valid = 1'b0; mret = 1'b0;
        check_eq("simul_rdata_pre", rd, 32'h1000);
        check_eq("simul_ack", ack, 1'b1);
        check_eq("simul_mepc", mepc, 32'h2000);
        csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check_eq("simul_mstatus", rd, 32'h1880);

        // timer interrupt with prescaler of 4
        csr_xfer(2'b10, 12'h300, 32'h8, rd, ill, ack);
        csr_xfer(2'b01, 12'h304, 32'h80, rd, ill, ack);
        csr_xfer(2'b01, 12'h7C2, 32'h0, rd, ill, ack);
        csr_xfer(2'b01, 12'h7C0, 32'h3, rd, ill, ack);
        csr_xfer(2'b01, 12'h7C1, 32'h0, rd, ill, ack);
        check_eq("timer_pre", timer_irq, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (timer_irq) found = 1'b1;
        end
        check_eq("timer_rise", found, 1'b1);
        check_eq("pending_lag", irq_pending, 1'b0);
        tick(1);
        check_eq("pending_set", irq_pending, 1'b1);
        csr_xfer(2'b00, 12'h344, 32'h0, rd, ill, ack);
        check_eq("mip_mtip", rd, 32'h80);
        csr_xfer(2'b01, 12'h344, 32'hFFFF_FFFF, rd, ill, ack);
        csr_xfer(2'b00, 12'h344, 32'h0, rd, ill, ack);
        check_eq("mip_msip_only", rd, 32'h88);

        // reset with a request in flight
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_inflight_ack", csr_ack, 1'b0);
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
        tick(1);
        check_eq("rst2_timer_irq", timer_irq, 1'b0);
        check_eq("rst2_mtvec", mtvec, 32'h8000_0000);
        resetn = 1'b0;
        tick(1);
        csr_xfer(2'b00, 12'h340, 32'h0, rd, ill, ack);
        check_eq("mscratch_after_rst", rd, 32'h0);
        check_eq("mscratch_ack", ack, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised successor to the machine-mode CSR file.
- Adds RISC-V CSRRW/CSRRS/CSRRC semantics over a 12-bit address, illegal-access detection, and a registered single-cycle read/ack handshake.
- Adds trap entry and mret sequencing, parametric-width cycle/instret counters, and a prescaled mtime/mtimecmp timer interrupt.
- Sits between the decode/execute stage and the trap controller of the core.

Parameters:
- XLEN, 32, data width of CSRs and buses.
- CNT_W, 64, implemented width of mcycle/minstret/mtime (33..64). Bits at CNT_W and above read 0.
- TIMER_DIV, 1, clk cycles per mtime tick (>=1).
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-high reset (asserted = 1).
- csr_req  in  1  access request, one per cycle.
- csr_op  in  2  01 RW, 10 RS, 11 RC; 00 behaves as a read with no write.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write/set/clear operand.
- csr_rdata  out  XLEN  old value of the addressed CSR.
- csr_ack  out  1  rdata/illegal valid.
- csr_illegal  out  1  unmapped address, or write to a read-only CSR.
- instret_inc  in  1  instruction retired.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  XLEN  mcause value.
- trap_pc  in  XLEN  faulting pc.
- trap_tval  in  XLEN  mtval value.
- mret  in  1  return from trap.
- irq_ext  in  1  external interrupt level.
- mtvec  out  XLEN  trap vector.
- mepc  out  XLEN  return pc.
- timer_irq  out  1  mtime >= mtimecmp.
- irq_pending  out  1  interrupt should be taken.

Behaviour:
- Address map:
  - 300 mstatus, 301 misa (RO-valued, writes ignored), 304 mie, 305 mtvec.
  - 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip (only MSIP, bit3, writable).
  - B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi.
  - 7C0/7C1 mtimecmp lo/hi, 7C2/7C3 mtime lo/hi.
  - F11..F14 mvendorid/marchid/mimpid/mhartid, all read-only.
- Any other address is illegal and reads 0.
- Handshake:
  - csr_req sampled at edge N.
  - csr_ack=1 for exactly one cycle after N, with csr_rdata = pre-write value and csr_illegal valid.
  - Any new value is visible from edge N onward.
- Write rules:
  - RW writes wdata; RS writes old|wdata; RC writes old&~wdata.
  - RS/RC with wdata==0 performs no write and is never illegal.
  - Any write to addr[11:10]==2'b11 is illegal and suppressed.
- Illegal access:
  - Reads rdata=0 and state is unchanged.
  - ack still pulses.
- Counters:
  - mcycle +1 every cycle; minstret +1 when instret_inc=1. Both wrap to 0 at 2^CNT_W.
  - A CSR write to a counter half in the same cycle wins over the increment.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; mtime +1 on the prescaler wrap.
  - timer_irq is registered: unsigned CNT_W compare of mtime >= mtimecmp.
  - mtimecmp resets to all-ones, so there is no spurious irq after reset.
- mip composition: MTIP (bit7) = timer_irq; MEIP (bit11) = irq_ext registered once.
- irq_pending is registered: mstatus.MIE & |(mie & mip).
- Trap entry on trap_valid:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_tval.
  - MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
- mret: MIE <= MPIE; MPIE <= 1.
- Simultaneous events:
  - Priority is trap_valid > mret > CSR write for any register touched by both.
  - A CSR read in the same cycle returns the pre-trap value, and ack still pulses.
  - trap_valid and mret together: trap only.
- Reset (asynchronous):
  - csr_rdata=0, csr_ack=0, csr_illegal=0, timer_irq=0, irq_pending=0.
  - mstatus/mie/mscratch/mepc/mcause/mtval/MSIP = 0; mtvec=MTVEC_RESET.
  - Counters, prescaler and mtime = 0.
  - A request in flight when reset asserts is dropped; no ack.

Optional Feature:
- Macro: CSR_COUNTINHIBIT_EN.
- Defined: mcountinhibit at 0x320 is read/write.
  - Bit0 (CY) freezes mcycle; bit2 (IR) freezes minstret; other bits read 0.
  - Reset value 0. CSR writes to frozen counters still apply.
- Undefined: 0x320 is an illegal address and the counters always run.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - csr_op encoding enum.
  - mstatus/mip bit indices (MIE=3, MPIE=7, MPP=12:11, MSIP=3, MTIP=7, MEIP=11).
  - Counter half-select constants.
- Sub-module csr_counter:
  - Parameter W; inputs enable, load_lo, load_hi, load data; output W-bit count; same reset convention.
  - Instantiated for mcycle, minstret and mtime.

Test Plan:
- Reset, then RW 305 with 0x100 -> ack next cycle with rdata=MTVEC_RESET; a following read returns 0x100; mtvec output = 0x100.
- RS 300 with 0x8, then RC 300 with 0x8 -> rdata 0x0 then 0x8; RS with wdata=0 to F14 -> rdata=HART_ID, illegal=0; RW F14 -> illegal=1, value unchanged.
- TIMER_DIV=4, mtimecmp=3, mie=0x80, MIE=1 -> timer_irq rises after mtime reaches 3 (about 12 clk); irq_pending one cycle later.
- trap_valid with pc=0x1002, cause=0x8000_0007, MIE=1 -> mepc=0x1000, MIE=0, MPIE=1; mret -> MIE=1, MPIE=1.
- RW B00 with 0xFFFF_FFFF, B80 with 0 -> two cycles later mcycle=0x1_0000_0000 (lo wraps, hi carries).
- Assert resetn while csr_req is high with an RW to 340 -> no ack, and mscratch reads 0 after reset.
